// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider.
//   div_state_e : controller states
//   WIDTH_DEF   : default operand/result width
//   DZ_QUOT     : all-ones quotient returned on divide-by-zero (sliced to WIDTH, WIDTH <= 64)
//   clog2()     : width of the iteration counter
package div_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [63:0] DZ_QUOT = '1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } div_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/div_seq_ctrl_if.sv
// Request/result bundle between the execute stage and the divider.
// Handshake: the divider accepts a request on any cycle it is idle and
// start==1 (start is a level sampled only while idle, no ready is returned);
// busy is high from the cycle after acceptance until and including the
// done cycle; done is a one-cycle pulse during which Quotient, Remainder
// and dz are valid (they also hold afterwards until the next completion).
//   master : start, uns, S, T out; busy, done, Quotient, Remainder, dz in
//   slave  : the reverse (the divider side)
interface div_seq_ctrl_if
  import div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic             start;
  logic             uns;
  logic [WIDTH-1:0] S;
  logic [WIDTH-1:0] T;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic             dz;

  modport master (
    output start, uns, S, T,
    input  busy, done, Quotient, Remainder, dz
  );

  modport slave (
    input  start, uns, S, T,
    output busy, done, Quotient, Remainder, dz
  );
endinterface

// File: rtl/div_step.sv
// One radix-2 restoring division step (purely combinational).
//   rem_in, quo_in : partial remainder and dividend/quotient shift register
//   divisor        : magnitude of the divisor
//   rem_out,quo_out: values after shifting {rem,quo} left one bit and a
//                    trial subtraction; quotient LSB = 1 when no borrow
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);
  // One extra bit: the shifted remainder can reach 2*divisor-1, and the
  // top bit of the difference is the borrow.
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  always_comb begin
    rem_sh = {rem_in, quo_in[WIDTH-1]};
    diff   = rem_sh - {1'b0, divisor};
    if (diff[WIDTH]) begin
      rem_out = rem_sh[WIDTH-1:0];
      quo_out = {quo_in[WIDTH-2:0], 1'b0};
    end else begin
      rem_out = diff[WIDTH-1:0];
      quo_out = {quo_in[WIDTH-2:0], 1'b1};
    end
  end
endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle signed/unsigned divider with its own controller.
//   clk, reset : rising-edge clock, synchronous active-low reset
//   bus        : request/result bundle (slave side), see div_seq_ctrl_if
//   dbg_state  : current controller state, for observation only
// Flow: IDLE captures operands, PREP takes magnitudes and signs (or
// short-cuts divide-by-zero to DONE), ITER runs WIDTH restoring steps,
// FIX applies signs and loads the result registers, DONE pulses done.
module div_seq_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic       clk,
  input  logic       reset,
  div_seq_ctrl_if.slave bus,
  output div_state_e dbg_state
);
  localparam int CW = clog2(WIDTH);

  div_state_e state_q, state_d;

  logic [WIDTH-1:0] s_q, s_d, t_q, t_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, div_q, div_d;
  logic [WIDTH-1:0] oq_q, oq_d, or_q, or_d;
  logic             uns_q, uns_d, qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             s_neg, t_neg;
  logic [WIDTH-1:0] step_rem, step_quo;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (div_q),
    .rem_out (step_rem),
    .quo_out (step_quo)
  );

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = PREP;
      PREP:    state_d = (t_q == '0) ? DONE : ITER;
      ITER:    if (cnt_q == '0) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bus.busy  = (state_q != IDLE);
    bus.done  = (state_q == DONE);
    dbg_state = state_q;
  end

  assign bus.Quotient  = oq_q;
  assign bus.Remainder = or_q;
  assign bus.dz        = dz_q;

  // Datapath next-state
  always_comb begin
    s_d    = s_q;
    t_d    = t_q;
    uns_d  = uns_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    div_d  = div_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    cnt_d  = cnt_q;
    oq_d   = oq_q;
    or_d   = or_q;
    dz_d   = dz_q;
    s_neg  = !uns_q && s_q[WIDTH-1];
    t_neg  = !uns_q && t_q[WIDTH-1];
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          s_d   = bus.S;
          t_d   = bus.T;
          uns_d = bus.uns;
        end
      end
      PREP: begin
        rem_d  = '0;
        quo_d  = s_neg ? -s_q : s_q;
        div_d  = t_neg ? -t_q : t_q;
        qneg_d = s_neg ^ t_neg;
        rneg_d = s_neg;
        cnt_d  = CW'(WIDTH - 1);
        if (t_q == '0) begin
          // Divide-by-zero result is published directly; the remainder is
          // the raw captured dividend, not its magnitude.
          oq_d = DZ_QUOT[WIDTH-1:0];
          or_d = s_q;
          dz_d = 1'b1;
        end
      end
      ITER: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - CW'(1);
      end
      FIX: begin
        // -MIN/-1 yields a positive 2^(WIDTH-1) magnitude whose bit pattern
        // is already the wrapped quotient, so no special case is needed.
        oq_d = qneg_q ? -quo_q : quo_q;
        or_d = rneg_q ? -rem_q : rem_q;
        dz_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s_q    <= '0;
      t_q    <= '0;
      uns_q  <= 1'b0;
      rem_q  <= '0;
      quo_q  <= '0;
      div_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      cnt_q  <= '0;
      oq_q   <= '0;
      or_q   <= '0;
      dz_q   <= 1'b0;
    end else begin
      s_q    <= s_d;
      t_q    <= t_d;
      uns_q  <= uns_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      div_q  <= div_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      cnt_q  <= cnt_d;
      oq_q   <= oq_d;
      or_q   <= or_d;
      dz_q   <= dz_d;
    end
  end
endmodule

// File: tb/tb_div_seq_ctrl.sv
// Bench for div_seq_ctrl (WIDTH=32): directed scenarios plus a randomized
// regression against a plain-arithmetic reference model.
module tb_div_seq_ctrl;
  import div_pkg::*;

  localparam int W = 32;
  localparam int NORM_LAT = W + 3;
  localparam int DZ_LAT = 2;
  localparam int N_RAND = 1000;

  logic       clk;
  logic       reset;
  div_state_e dbg_state;
  int         total;
  int         bad;

  div_seq_ctrl_if #(.WIDTH(W)) bus ();

  div_seq_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Reference model: arithmetic straight from the divide rules.
  function automatic void ref_div(input logic [W-1:0] s, input logic [W-1:0] t, input logic u,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    longint ss, tt;
    if (t == '0) begin
      q = '1;
      r = s;
      z = 1'b1;
    end else if (u) begin
      q = s / t;
      r = s % t;
      z = 1'b0;
    end else begin
      ss = longint'($signed(s));
      tt = longint'($signed(t));
      q  = 32'(ss / tt);
      r  = 32'(ss % tt);
      z  = 1'b0;
    end
  endfunction

  // Driver: issues one division starting #1 after a clock edge in IDLE.
  // poke_at  : if >0, re-pulse start with other operands before edge poke_at
  // in_done  : also drive start during the done cycle
  // Returns at #1 after the edge following done (divider back in IDLE).
  task automatic do_div(input logic [W-1:0] s, input logic [W-1:0] t, input logic u,
                        input int poke_at, input bit in_done,
                        output logic [W-1:0] q, output logic [W-1:0] r, output logic z,
                        output int lat);
    bit seen, busy_bad;
    seen = 0;
    busy_bad = 0;
    lat = -1;
    q = 'x; r = 'x; z = 1'bx;
    bus.start = 1'b1; bus.S = s; bus.T = t; bus.uns = u;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.S = $urandom; bus.T = $urandom; bus.uns = 1'($urandom_range(0, 1));
    if (bus.busy !== 1'b1) busy_bad = 1;
    for (int k = 1; k <= 100 && !seen; k++) begin
      if (k == poke_at) begin
        bus.start = 1'b1; bus.S = 32'd50; bus.T = 32'd5; bus.uns = 1'b1;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.busy !== 1'b1) busy_bad = 1;
      if (bus.done === 1'b1) begin
        seen = 1;
        lat = k + 1;
        q = bus.Quotient; r = bus.Remainder; z = bus.dz;
      end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL done_timeout: no done within 100 cycles for S=%h T=%h uns=%0b", s, t, u);
    end
    total++;
    if (busy_bad) begin
      bad++;
      $display("FAIL busy_window: busy dropped before done for S=%h T=%h uns=%0b", s, t, u);
    end
    if (in_done) begin
      bus.start = 1'b1; bus.S = 32'd99; bus.T = 32'd3; bus.uns = 1'b1;
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    total++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL after_done: done=%b busy=%b expected done=0 busy=0", bus.done, bus.busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.start = 1'b0; bus.uns = 1'b0; bus.S = '0; bus.T = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({bus.busy, bus.done, bus.Quotient, bus.Remainder, bus.dz} !== '0 || dbg_state !== IDLE) begin
      bad++;
      $display("FAIL reset_state: busy=%b done=%b Q=%h R=%h dz=%b state=%0d expected all 0 / IDLE",
               bus.busy, bus.done, bus.Quotient, bus.Remainder, bus.dz, dbg_state);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    total++;
    if (bus.busy !== 1'b0 || dbg_state !== IDLE) begin
      bad++;
      $display("FAIL idle_after_reset: busy=%b state=%0d expected 0 / IDLE", bus.busy, dbg_state);
    end
  endtask

  task automatic test_unsigned_basic();
    logic [W-1:0] q, r; logic z; int lat;
    do_div(32'd100, 32'd7, 1'b1, 0, 0, q, r, z, lat);
    total++;
    if ({q, r, z} !== {32'd14, 32'd2, 1'b0}) begin
      bad++;
      $display("FAIL unsigned_basic: Q=%0d R=%0d dz=%b expected Q=14 R=2 dz=0", q, r, z);
    end
    total++;
    if (lat !== NORM_LAT) begin
      bad++;
      $display("FAIL unsigned_latency: got %0d expected %0d", lat, NORM_LAT);
    end
  endtask

  task automatic test_sign_matrix();
    logic [W-1:0] sv[3], tv[3], eq[3], er[3];
    logic [W-1:0] q, r; logic z; int lat;
    sv[0] = 32'hFFFF_FFF9; tv[0] = 32'd2;          eq[0] = 32'hFFFF_FFFD; er[0] = 32'hFFFF_FFFF;
    sv[1] = 32'd7;         tv[1] = 32'hFFFF_FFFE;  eq[1] = 32'hFFFF_FFFD; er[1] = 32'd1;
    sv[2] = 32'hFFFF_FFF9; tv[2] = 32'hFFFF_FFFE;  eq[2] = 32'd3;         er[2] = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      do_div(sv[i], tv[i], 1'b0, 0, 0, q, r, z, lat);
      total++;
      if ({q, r, z} !== {eq[i], er[i], 1'b0}) begin
        bad++;
        $display("FAIL sign_matrix_%0d: Q=%h R=%h dz=%b expected Q=%h R=%h dz=0",
                 i, q, r, z, eq[i], er[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    logic [W-1:0] q, r; logic z; int lat;
    for (int m = 0; m < 2; m++) begin
      do_div(32'h1234_5678, 32'd0, 1'(m), 0, 0, q, r, z, lat);
      total++;
      if ({q, r, z} !== {32'hFFFF_FFFF, 32'h1234_5678, 1'b1}) begin
        bad++;
        $display("FAIL div_zero_uns%0d: Q=%h R=%h dz=%b expected Q=ffffffff R=12345678 dz=1", m, q, r, z);
      end
      total++;
      if (lat !== DZ_LAT) begin
        bad++;
        $display("FAIL div_zero_latency_uns%0d: got %0d expected %0d", m, lat, DZ_LAT);
      end
    end
    // dz must clear on the next normal completion
    do_div(32'd10, 32'd5, 1'b0, 0, 0, q, r, z, lat);
    total++;
    if ({q, r, z} !== {32'd2, 32'd0, 1'b0}) begin
      bad++;
      $display("FAIL dz_clear: Q=%h R=%h dz=%b expected Q=2 R=0 dz=0", q, r, z);
    end
  endtask

  task automatic test_extremes();
    logic [W-1:0] q, r; logic z; int lat;
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 0, q, r, z, lat);
    total++;
    if ({q, r, z} !== {32'h8000_0000, 32'd0, 1'b0}) begin
      bad++;
      $display("FAIL signed_overflow: Q=%h R=%h dz=%b expected Q=80000000 R=0 dz=0", q, r, z);
    end
    do_div(32'hFFFF_FFFF, 32'd1, 1'b1, 0, 0, q, r, z, lat);
    total++;
    if ({q, r, z} !== {32'hFFFF_FFFF, 32'd0, 1'b0}) begin
      bad++;
      $display("FAIL unsigned_max: Q=%h R=%h dz=%b expected Q=ffffffff R=0 dz=0", q, r, z);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] q, r; logic z; int lat;
    // re-pulse during ITER and again in the done cycle; both ignored
    do_div(32'd1000, 32'd3, 1'b1, 6, 1, q, r, z, lat);
    total++;
    if ({q, r, z} !== {32'd333, 32'd1, 1'b0}) begin
      bad++;
      $display("FAIL start_ignored: Q=%0d R=%0d dz=%b expected Q=333 R=1 dz=0", q, r, z);
    end
    total++;
    if (lat !== NORM_LAT) begin
      bad++;
      $display("FAIL start_ignored_latency: got %0d expected %0d", lat, NORM_LAT);
    end
    // immediate next request from IDLE
    do_div(32'hFFFF_FF9C, 32'd9, 1'b0, 0, 0, q, r, z, lat);
    total++;
    if ({q, r, z} !== {32'hFFFF_FFF5, 32'hFFFF_FFFF, 1'b0}) begin
      bad++;
      $display("FAIL back_to_back: Q=%h R=%h dz=%b expected Q=fffffff5 R=ffffffff dz=0", q, r, z);
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] q, r, eq, er; logic z, ez; int lat;
    bit done_seen;
    do_div(32'd1000, 32'd7, 1'b1, 0, 0, q, r, z, lat);  // leaves non-zero outputs
    bus.start = 1'b1; bus.S = 32'd12345; bus.T = 32'd17; bus.uns = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    total++;
    if (dbg_state !== ITER) begin
      bad++;
      $display("FAIL reset_mid_in_iter: state=%0d expected ITER", dbg_state);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({bus.busy, bus.done, bus.Quotient, bus.Remainder, bus.dz} !== '0 || dbg_state !== IDLE) begin
      bad++;
      $display("FAIL reset_mid_clear: busy=%b done=%b Q=%h R=%h dz=%b expected all 0",
               bus.busy, bus.done, bus.Quotient, bus.Remainder, bus.dz);
    end
    reset = 1'b1;
    done_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen = 1;
    end
    total++;
    if (done_seen) begin
      bad++;
      $display("FAIL reset_mid_no_done: done/busy seen after abandoned division, expected none");
    end
    do_div(32'hFFFF_CFC7, 32'd17, 1'b0, 0, 0, q, r, z, lat);
    ref_div(32'hFFFF_CFC7, 32'd17, 1'b0, eq, er, ez);
    total++;
    if ({q, r, z} !== {eq, er, ez}) begin
      bad++;
      $display("FAIL reset_mid_fresh: Q=%h R=%h dz=%b expected Q=%h R=%h dz=%b", q, r, z, eq, er, ez);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] s, t, q, r, eq, er; logic u, z, ez; int lat, elat;
    for (int i = 0; i < N_RAND; i++) begin
      s = $urandom;
      t = $urandom;
      u = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: t = '0;
        1: t = 32'($urandom_range(1, 15));
        2: begin s = 32'h8000_0000; t = 32'hFFFF_FFFF; end
        3: t = t >> $urandom_range(1, 31);
        4: s = 32'($urandom_range(0, 200));
        default: ;
      endcase
      ref_div(s, t, u, eq, er, ez);
      elat = ez ? DZ_LAT : NORM_LAT;
      do_div(s, t, u, 0, 0, q, r, z, lat);
      total++;
      if ({q, r, z} !== {eq, er, ez}) begin
        bad++;
        $display("FAIL rand_result: S=%h T=%h uns=%b got Q=%h R=%h dz=%b expected Q=%h R=%h dz=%b",
                 s, t, u, q, r, z, eq, er, ez);
      end
      total++;
      if (lat !== elat) begin
        bad++;
        $display("FAIL rand_latency: S=%h T=%h uns=%b got %0d expected %0d", s, t, u, lat, elat);
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_unsigned_basic();
    test_sign_matrix();
    test_div_zero();
    test_extremes();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
